// File: rtl/xrisc_multi_controller_pkg.sv
// Shared encodings for the multicycle X-RISC controller: FSM states, opcodes,
// mux select codes and ALU operation codes.
package xrisc_ctrl_pkg;

    localparam int unsigned OP_W    = 7;
    localparam int unsigned F3_W    = 3;
    localparam int unsigned STATE_W = 4;
    localparam int unsigned SEL_W   = 2;
    localparam int unsigned ALUC_W  = 3;

    typedef enum logic [STATE_W-1:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9,
        S_JAL      = 4'd10
    } state_t;

    localparam logic [OP_W-1:0] OP_LW     = 7'b0000011;
    localparam logic [OP_W-1:0] OP_SW     = 7'b0100011;
    localparam logic [OP_W-1:0] OP_RTYPE  = 7'b0110011;
    localparam logic [OP_W-1:0] OP_ITYPE  = 7'b0010011;
    localparam logic [OP_W-1:0] OP_BRANCH = 7'b1100011;
    localparam logic [OP_W-1:0] OP_JAL    = 7'b1101111;

    typedef enum logic [SEL_W-1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10
    } alu_op_t;

    localparam logic [SEL_W-1:0] SRCA_PC    = 2'b00;
    localparam logic [SEL_W-1:0] SRCA_OLDPC = 2'b01;
    localparam logic [SEL_W-1:0] SRCA_RD1   = 2'b10;

    localparam logic [SEL_W-1:0] SRCB_RD2  = 2'b00;
    localparam logic [SEL_W-1:0] SRCB_IMM  = 2'b01;
    localparam logic [SEL_W-1:0] SRCB_FOUR = 2'b10;

    localparam logic [SEL_W-1:0] RES_ALUOUT    = 2'b00;
    localparam logic [SEL_W-1:0] RES_DATA      = 2'b01;
    localparam logic [SEL_W-1:0] RES_ALURESULT = 2'b10;

    localparam logic [SEL_W-1:0] IMM_I = 2'b00;
    localparam logic [SEL_W-1:0] IMM_S = 2'b01;
    localparam logic [SEL_W-1:0] IMM_B = 2'b10;
    localparam logic [SEL_W-1:0] IMM_J = 2'b11;

    localparam logic [ALUC_W-1:0] ALU_ADD = 3'b000;
    localparam logic [ALUC_W-1:0] ALU_SUB = 3'b001;
    localparam logic [ALUC_W-1:0] ALU_AND = 3'b010;
    localparam logic [ALUC_W-1:0] ALU_OR  = 3'b011;
    localparam logic [ALUC_W-1:0] ALU_SLT = 3'b101;

    // Immediate format depends only on the opcode, independent of state.
    function automatic logic [SEL_W-1:0] imm_src_of(input logic [OP_W-1:0] op);
        case (op)
            OP_SW:     return IMM_S;
            OP_BRANCH: return IMM_B;
            OP_JAL:    return IMM_J;
            default:   return IMM_I;
        endcase
    endfunction

endpackage

// File: rtl/xrisc_multi_controller_if.sv
// Controller <-> datapath bundle: instruction fields and Zero in, every
// select / enable plus the debug state out.
interface xrisc_multi_controller_if;

    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       Zero;

    logic       PCWrite;
    logic       AdrSrc;
    logic       MemWrite;
    logic       IRWrite;
    logic [1:0] ResultSrc;
    logic [1:0] ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] ImmSrc;
    logic [2:0] ALUControl;
    logic       RegWrite;
    logic       InstrDone;
    logic       Illegal;
    logic [3:0] state_dbg;

    modport master (
        input  op, funct3, funct7b5, Zero,
        output PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
               ImmSrc, ALUControl, RegWrite, InstrDone, Illegal, state_dbg
    );

    modport slave (
        output op, funct3, funct7b5, Zero,
        input  PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
               ImmSrc, ALUControl, RegWrite, InstrDone, Illegal, state_dbg
    );

endinterface

// File: rtl/xrisc_alu_decoder.sv
// Maps the FSM's ALUOp plus funct fields to the ALU operation code.
module xrisc_alu_decoder
    import xrisc_ctrl_pkg::*;
(
    input  alu_op_t             alu_op_i,
    input  logic                op5_i,
    input  logic [F3_W-1:0]     funct3_i,
    input  logic                funct7b5_i,
    output logic [ALUC_W-1:0]   alu_control_o
);

    always_comb begin
        alu_control_o = ALU_ADD;
        case (alu_op_i)
            ALUOP_ADD: alu_control_o = ALU_ADD;
            ALUOP_SUB: alu_control_o = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct3_i)
                    // Only R-type may subtract; addi with imm[10]=1 must still add.
                    3'b000:  alu_control_o = (op5_i & funct7b5_i) ? ALU_SUB : ALU_ADD;
                    3'b010:  alu_control_o = ALU_SLT;
                    3'b110:  alu_control_o = ALU_OR;
                    3'b111:  alu_control_o = ALU_AND;
                    default: alu_control_o = ALU_ADD;
                endcase
            end
            default:   alu_control_o = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/xrisc_multi_controller.sv
// Moore control FSM for the multicycle X-RISC core: one state per cycle,
// driving all datapath selects and write enables.
module xrisc_multi_controller
    import xrisc_ctrl_pkg::*;
#(
    parameter state_t RESET_STATE = S_FETCH
) (
    input  logic                       clk,
    input  logic                       reset,
    xrisc_multi_controller_if.master   bus
);

    state_t              state_q, state_d;
    alu_op_t             alu_op;
    logic                pc_update, branch;
    logic                adr_src, mem_write, ir_write, reg_write;
    logic                instr_done, illegal;
    logic [SEL_W-1:0]    result_src, alu_src_a, alu_src_b;
    logic [ALUC_W-1:0]   alu_control;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= RESET_STATE;
        else       state_q <= state_d;
    end

    // Next state and raw per-state outputs.
    always_comb begin
        state_d    = S_FETCH;
        alu_op     = ALUOP_ADD;
        pc_update  = 1'b0;
        branch     = 1'b0;
        adr_src    = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        reg_write  = 1'b0;
        instr_done = 1'b0;
        illegal    = 1'b0;
        result_src = RES_ALUOUT;
        alu_src_a  = SRCA_PC;
        alu_src_b  = SRCB_RD2;

        case (state_q)
            S_FETCH: begin
                ir_write   = 1'b1;
                pc_update  = 1'b1;
                alu_src_b  = SRCB_FOUR;
                result_src = RES_ALURESULT;
                state_d    = S_DECODE;
            end
            S_DECODE: begin
                alu_src_a = SRCA_OLDPC;
                alu_src_b = SRCB_IMM;
                case (bus.op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_EXECR;
                    OP_ITYPE:     state_d = S_EXECI;
                    OP_BRANCH:    state_d = S_BRANCH;
                    OP_JAL:       state_d = S_JAL;
                    default: begin
                        illegal    = 1'b1;
                        instr_done = 1'b1;
                        state_d    = S_FETCH;
                    end
                endcase
            end
            S_MEMADR: begin
                alu_src_a = SRCA_RD1;
                alu_src_b = SRCB_IMM;
                state_d   = bus.op[5] ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                adr_src = 1'b1;
                state_d = S_MEMWB;
            end
            S_MEMWB: begin
                result_src = RES_DATA;
                reg_write  = 1'b1;
                instr_done = 1'b1;
            end
            S_MEMWRITE: begin
                adr_src    = 1'b1;
                mem_write  = 1'b1;
                instr_done = 1'b1;
            end
            S_EXECR: begin
                alu_src_a = SRCA_RD1;
                alu_op    = ALUOP_FUNCT;
                state_d   = S_ALUWB;
            end
            S_EXECI: begin
                alu_src_a = SRCA_RD1;
                alu_src_b = SRCB_IMM;
                alu_op    = ALUOP_FUNCT;
                state_d   = S_ALUWB;
            end
            S_ALUWB: begin
                reg_write  = 1'b1;
                instr_done = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a  = SRCA_RD1;
                alu_op     = ALUOP_SUB;
                branch     = 1'b1;
                instr_done = 1'b1;
            end
            S_JAL: begin
                alu_src_a = SRCA_OLDPC;
                alu_src_b = SRCB_FOUR;
                pc_update = 1'b1;
                state_d   = S_ALUWB;
            end
            default: state_d = S_FETCH;
        endcase
    end

    xrisc_alu_decoder u_alu_dec (
        .alu_op_i      (alu_op),
        .op5_i         (bus.op[5]),
        .funct3_i      (bus.funct3),
        .funct7b5_i    (bus.funct7b5),
        .alu_control_o (alu_control)
    );

    // funct3[0] distinguishes bne from beq; reset masks every enable.
    assign bus.PCWrite    = ~reset & (pc_update | (branch & (bus.Zero ^ bus.funct3[0])));
    assign bus.IRWrite    = ~reset & ir_write;
    assign bus.MemWrite   = ~reset & mem_write;
    assign bus.RegWrite   = ~reset & reg_write;
    assign bus.InstrDone  = ~reset & instr_done;
    assign bus.Illegal    = ~reset & illegal;
    assign bus.AdrSrc     = adr_src;
    assign bus.ResultSrc  = result_src;
    assign bus.ALUSrcA    = alu_src_a;
    assign bus.ALUSrcB    = alu_src_b;
    assign bus.ALUControl = alu_control;
    assign bus.ImmSrc     = imm_src_of(bus.op);
    assign bus.state_dbg  = state_q;

endmodule

// File: tb/tb_xrisc_multi_controller.sv
// Directed, table-driven check of the X-RISC multicycle controller.
module tb_xrisc_multi_controller;

    localparam logic [6:0] LW  = 7'b0000011;
    localparam logic [6:0] SW  = 7'b0100011;
    localparam logic [6:0] RT  = 7'b0110011;
    localparam logic [6:0] IT  = 7'b0010011;
    localparam logic [6:0] BR  = 7'b1100011;
    localparam logic [6:0] JL  = 7'b1101111;
    localparam logic [6:0] BAD = 7'b1111111;

    typedef struct packed {
        logic [3:0] st;
        logic       pcw, adr, mw, irw, rw;
        logic [1:0] rs, a, b, imm;
        logic [2:0] alu;
        logic       dn, il;
    } outs_t;

    typedef struct packed {
        logic [6:0] op;
        logic [2:0] f3;
        logic       f7;
        logic       z;
        outs_t      want;
    } vec_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;
    vec_t vecs[$];

    xrisc_multi_controller_if bus ();

    xrisc_multi_controller dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic outs_t o(input logic [3:0] st, input logic pcw, adr, mw, irw, rw,
                                input logic [1:0] rs, a, b, imm, input logic [2:0] alu,
                                input logic dn, il);
        outs_t r;
        r = '{st: st, pcw: pcw, adr: adr, mw: mw, irw: irw, rw: rw,
              rs: rs, a: a, b: b, imm: imm, alu: alu, dn: dn, il: il};
        return r;
    endfunction

    function automatic void add(input logic [6:0] op, input logic [2:0] f3,
                                input logic f7, z, input outs_t w);
        vec_t v;
        v.op = op; v.f3 = f3; v.f7 = f7; v.z = z; v.want = w;
        vecs.push_back(v);
    endfunction

    // FETCH and DECODE rows depend on the instruction only through ImmSrc.
    function automatic void add_fd(input logic [6:0] op, input logic [2:0] f3,
                                   input logic f7, z, input logic [1:0] imm);
        add(op, f3, f7, z, o(4'd0, 1,0,0,1,0, 2'b10,2'b00,2'b10, imm, 3'b000, 0,0));
        add(op, f3, f7, z, o(4'd1, 0,0,0,0,0, 2'b00,2'b01,2'b01, imm, 3'b000, 0,0));
    endfunction

    function automatic outs_t aluwb(input logic [1:0] imm);
        return o(4'd8, 0,0,0,0,1, 2'b00,2'b00,2'b00, imm, 3'b000, 1,0);
    endfunction

    function automatic outs_t actual();
        outs_t r;
        r = '{st: bus.state_dbg, pcw: bus.PCWrite, adr: bus.AdrSrc, mw: bus.MemWrite,
              irw: bus.IRWrite, rw: bus.RegWrite, rs: bus.ResultSrc, a: bus.ALUSrcA,
              b: bus.ALUSrcB, imm: bus.ImmSrc, alu: bus.ALUControl,
              dn: bus.InstrDone, il: bus.Illegal};
        return r;
    endfunction

    task automatic check(input string name, input outs_t want);
        outs_t got;
        got = actual();
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got st=%0d pcw%b adr%b mw%b irw%b rw%b rs%b a%b b%b imm%b alu%b dn%b il%b want st=%0d pcw%b adr%b mw%b irw%b rw%b rs%b a%b b%b imm%b alu%b dn%b il%b",
                     name, got.st, got.pcw, got.adr, got.mw, got.irw, got.rw, got.rs, got.a,
                     got.b, got.imm, got.alu, got.dn, got.il, want.st, want.pcw, want.adr,
                     want.mw, want.irw, want.rw, want.rs, want.a, want.b, want.imm, want.alu,
                     want.dn, want.il);
        end
    endtask

    task automatic drive(input logic [6:0] op, input logic [2:0] f3, input logic f7, z);
        bus.op = op; bus.funct3 = f3; bus.funct7b5 = f7; bus.Zero = z;
    endtask

    initial begin
        // lw: 5 cycles, RegWrite with ResultSrc=Data only in the last
        add_fd(LW, 3'b000, 0, 0, 2'b00);
        add(LW, 3'b000, 0, 0, o(4'd2, 0,0,0,0,0, 2'b00,2'b10,2'b01, 2'b00, 3'b000, 0,0));
        add(LW, 3'b000, 0, 0, o(4'd3, 0,1,0,0,0, 2'b00,2'b00,2'b00, 2'b00, 3'b000, 0,0));
        add(LW, 3'b000, 0, 0, o(4'd4, 0,0,0,0,1, 2'b01,2'b00,2'b00, 2'b00, 3'b000, 1,0));
        // sw
        add_fd(SW, 3'b010, 0, 0, 2'b01);
        add(SW, 3'b010, 0, 0, o(4'd2, 0,0,0,0,0, 2'b00,2'b10,2'b01, 2'b01, 3'b000, 0,0));
        add(SW, 3'b010, 0, 0, o(4'd5, 0,1,1,0,0, 2'b00,2'b00,2'b00, 2'b01, 3'b000, 1,0));
        // R sub, addi with funct7b5=1, and/or/slt, ori
        add_fd(RT, 3'b000, 1, 0, 2'b00);
        add(RT, 3'b000, 1, 0, o(4'd6, 0,0,0,0,0, 2'b00,2'b10,2'b00, 2'b00, 3'b001, 0,0));
        add(RT, 3'b000, 1, 0, aluwb(2'b00));
        add_fd(IT, 3'b000, 1, 0, 2'b00);
        add(IT, 3'b000, 1, 0, o(4'd7, 0,0,0,0,0, 2'b00,2'b10,2'b01, 2'b00, 3'b000, 0,0));
        add(IT, 3'b000, 1, 0, aluwb(2'b00));
        add_fd(RT, 3'b111, 0, 1, 2'b00);
        add(RT, 3'b111, 0, 1, o(4'd6, 0,0,0,0,0, 2'b00,2'b10,2'b00, 2'b00, 3'b010, 0,0));
        add(RT, 3'b111, 0, 1, aluwb(2'b00));
        add_fd(RT, 3'b110, 0, 0, 2'b00);
        add(RT, 3'b110, 0, 0, o(4'd6, 0,0,0,0,0, 2'b00,2'b10,2'b00, 2'b00, 3'b011, 0,0));
        add(RT, 3'b110, 0, 0, aluwb(2'b00));
        add_fd(RT, 3'b010, 0, 0, 2'b00);
        add(RT, 3'b010, 0, 0, o(4'd6, 0,0,0,0,0, 2'b00,2'b10,2'b00, 2'b00, 3'b101, 0,0));
        add(RT, 3'b010, 0, 0, aluwb(2'b00));
        add_fd(IT, 3'b110, 0, 0, 2'b00);
        add(IT, 3'b110, 0, 0, o(4'd7, 0,0,0,0,0, 2'b00,2'b10,2'b01, 2'b00, 3'b011, 0,0));
        add(IT, 3'b110, 0, 0, aluwb(2'b00));
        // beq/bne, taken and not taken
        add_fd(BR, 3'b000, 0, 1, 2'b10);
        add(BR, 3'b000, 0, 1, o(4'd9, 1,0,0,0,0, 2'b00,2'b10,2'b00, 2'b10, 3'b001, 1,0));
        add_fd(BR, 3'b000, 0, 0, 2'b10);
        add(BR, 3'b000, 0, 0, o(4'd9, 0,0,0,0,0, 2'b00,2'b10,2'b00, 2'b10, 3'b001, 1,0));
        add_fd(BR, 3'b001, 0, 0, 2'b10);
        add(BR, 3'b001, 0, 0, o(4'd9, 1,0,0,0,0, 2'b00,2'b10,2'b00, 2'b10, 3'b001, 1,0));
        add_fd(BR, 3'b001, 0, 1, 2'b10);
        add(BR, 3'b001, 0, 1, o(4'd9, 0,0,0,0,0, 2'b00,2'b10,2'b00, 2'b10, 3'b001, 1,0));
        // jal
        add_fd(JL, 3'b000, 0, 0, 2'b11);
        add(JL, 3'b000, 0, 0, o(4'd10, 1,0,0,0,0, 2'b00,2'b01,2'b10, 2'b11, 3'b000, 0,0));
        add(JL, 3'b000, 0, 0, aluwb(2'b11));
        // illegal opcode: 2 cycles, then straight back to FETCH
        add(BAD, 3'b000, 0, 0, o(4'd0, 1,0,0,1,0, 2'b10,2'b00,2'b10, 2'b00, 3'b000, 0,0));
        add(BAD, 3'b000, 0, 0, o(4'd1, 0,0,0,0,0, 2'b00,2'b01,2'b01, 2'b00, 3'b000, 1,1));
        add(LW, 3'b000, 0, 0, o(4'd0, 1,0,0,1,0, 2'b10,2'b00,2'b10, 2'b00, 3'b000, 0,0));

        drive(LW, 3'b000, 0, 0);
        #17;
        check("reset_hold", o(4'd0, 0,0,0,0,0, 2'b10,2'b00,2'b10, 2'b00, 3'b000, 0,0));
        #5;
        reset = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].op, vecs[i].f3, vecs[i].f7, vecs[i].z);
            #1;
            check($sformatf("vec%0d", i), vecs[i].want);
            @(negedge clk);
        end

        // Now in DECODE of lw: reset aborts it, state returns to FETCH immediately.
        reset = 1'b1;
        #1;
        check("abort_lw", o(4'd0, 0,0,0,0,0, 2'b10,2'b00,2'b10, 2'b00, 3'b000, 0,0));
        @(negedge clk);
        reset = 1'b0;

        // sw, then reset asserted mid-cycle in S_MEMWRITE.
        drive(SW, 3'b010, 0, 0);
        #1;
        check("sw_fetch", o(4'd0, 1,0,0,1,0, 2'b10,2'b00,2'b10, 2'b01, 3'b000, 0,0));
        @(negedge clk);
        @(negedge clk);
        #1;
        check("sw_memadr", o(4'd2, 0,0,0,0,0, 2'b00,2'b10,2'b01, 2'b01, 3'b000, 0,0));
        @(negedge clk);
        #1;
        check("sw_memwrite", o(4'd5, 0,1,1,0,0, 2'b00,2'b00,2'b00, 2'b01, 3'b000, 1,0));
        #1;
        reset = 1'b1;
        #1;
        check("rst_in_memwrite", o(4'd0, 0,0,0,0,0, 2'b10,2'b00,2'b10, 2'b01, 3'b000, 0,0));
        @(posedge clk);
        #1;
        check("rst_across_edge", o(4'd0, 0,0,0,0,0, 2'b10,2'b00,2'b10, 2'b01, 3'b000, 0,0));
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("post_rst_fetch", o(4'd0, 1,0,0,1,0, 2'b10,2'b00,2'b10, 2'b01, 3'b000, 0,0));
        @(negedge clk);
        #1;
        check("post_rst_decode", o(4'd1, 0,0,0,0,0, 2'b00,2'b01,2'b01, 2'b01, 3'b000, 0,0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
